// File: rtl/vga_ctrl_pkg.sv
`timescale 1ns/1ps
// vga_ctrl_pkg: register indices, mode encodings and field positions shared
// by the VGA control register block and its bench.
package vga_ctrl_pkg;

  // Register index as presented on addr (CPU A1-A3).
  typedef enum logic [2:0] {
    REG_MODE   = 3'd0,
    REG_PLANE  = 3'd1,
    REG_STATUS = 3'd2,
    REG_IRQEN  = 3'd3,
    REG_FRAME  = 3'd4
  } reg_idx_e;

  // Graphics mode driven to the VGA timing stage.
  typedef enum logic [1:0] {
    MODE_TEXT    = 2'd0,
    MODE_320X200 = 2'd1,
    MODE_320X400 = 2'd2,
    MODE_640X200 = 2'd3
  } mode_e;

  // PLANE register fields (write: select + defer, read: plane + pending).
  localparam int PLANE_SEL_BIT   = 0;
  localparam int PLANE_DEFER_BIT = 1;

  // STATUS register fields.
  localparam int STATUS_VSYNC_BIT = 0;
  localparam int STATUS_FLAG_BIT  = 1;
  localparam int STATUS_PEND_BIT  = 2;
  localparam int STATUS_CLEAR_BIT = 1;

  // IRQEN register field.
  localparam int IRQEN_BIT = 0;

endpackage

// File: rtl/sync_edge.sv
`timescale 1ns/1ps
// sync_edge: SYNC_STAGES-deep synchroniser with rise/fall pulses.
// Pulses are decoded only from samples taken after reset release, so a
// level that was already active through reset never produces an edge.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT        = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  genvar gi;

  logic [SYNC_STAGES-1:0] chain_reg;
  logic [SYNC_STAGES-1:0] chain_next;
  logic [SYNC_STAGES-1:0] vld_reg;
  logic [SYNC_STAGES-1:0] vld_next;
  logic                   prev_reg;
  logic                   prev_vld_reg;

  // Data and "real sample" marker shift side by side through the chain.
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign chain_next[gi] = d;
        assign vld_next[gi]   = 1'b1;
      end else begin : g_rest
        assign chain_next[gi] = chain_reg[gi-1];
        assign vld_next[gi]   = vld_reg[gi-1];
      end
    end
  endgenerate

  assign q = chain_reg[SYNC_STAGES-1];

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_reg    <= {SYNC_STAGES{INIT}};
      vld_reg      <= '0;
      prev_reg     <= INIT;
      prev_vld_reg <= 1'b0;
    end else begin
      chain_reg    <= chain_next;
      vld_reg      <= vld_next;
      prev_reg     <= q;
      prev_vld_reg <= vld_reg[SYNC_STAGES-1];
    end
  end

  // Both operands are flop outputs, so the pulses are glitch-free and last
  // exactly the cycle in which the synchronised level changes.
  assign rise = prev_vld_reg & ~prev_reg &  q;
  assign fall = prev_vld_reg &  prev_reg & ~q;

endmodule

// File: rtl/vga_ctrl_regs.sv
`timescale 1ns/1ps
// vga_ctrl_regs: 8086 I/O register block feeding mode/plane to the VGA stage,
// with vsync-deferred page flips, sticky frame flag, frame counter and irq.
module vga_ctrl_regs
  import vga_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_W     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       _cs,
  input  logic [2:0] addr,
  input  logic       _rd,
  input  logic       _wr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_en,
  input  logic       vsync,
  output logic [1:0] mode,
  output logic       plane,
  output logic       irq
);

  genvar gi;

  // Plain synchronisers for {_cs, _rd, addr, din}, idle at inactive levels.
  localparam int             BUS_W    = 13;
  localparam logic [BUS_W-1:0] BUS_IDLE = {1'b1, 1'b1, 3'b000, 8'h00};

  logic [BUS_W-1:0] bus_reg  [SYNC_STAGES];
  logic [BUS_W-1:0] bus_next [SYNC_STAGES];
  logic             cs_s;
  logic             rd_s;
  logic [2:0]       addr_s;
  logic [7:0]       din_s;

  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_bus_stage
      if (gi == 0) begin : g_first
        assign bus_next[gi] = {_cs, _rd, addr, din};
      end else begin : g_rest
        assign bus_next[gi] = bus_reg[gi-1];
      end
    end
  endgenerate

  // Bus synchroniser chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) bus_reg[i] <= BUS_IDLE;
    end else begin
      bus_reg <= bus_next;
    end
  end

  assign {cs_s, rd_s, addr_s, din_s} = bus_reg[SYNC_STAGES-1];

  // Edge-detecting synchronisers for the write strobe and vsync.
  logic wr_s, wr_rise, wr_fall;
  logic vs_s, vs_rise, vs_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_wr (
    .clock (clock),
    .reset (reset),
    .d     (_wr),
    .q     (wr_s),
    .rise  (wr_rise),
    .fall  (wr_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_vs (
    .clock (clock),
    .reset (reset),
    .d     (vsync),
    .q     (vs_s),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  // Only the falling edge of _wr and the rising edge of vsync matter here.
  logic unused_bits;
  assign unused_bits = ^{din_s[7:2], wr_s, wr_rise, vs_fall};

  logic wr_commit;
  logic frame_ev;
  assign wr_commit = wr_fall & ~cs_s;
  assign frame_ev  = vs_rise;

  // Architectural state.
  mode_e              mode_reg,       mode_next;
  logic               plane_reg,      plane_next;
  logic               pending_reg,    pending_next;
  logic               pend_plane_reg, pend_plane_next;
  logic               irqen_reg,      irqen_next;
  logic               flag_reg,       flag_next;
  logic [FRAME_W-1:0] cnt_reg,        cnt_next;
  logic [7:0]         dout_reg,       rd_data;
  logic               dout_en_reg;
  logic               irq_reg;

  // Next state: frame event first, CPU write second, except that a STATUS
  // clear never overrides a frame event arriving in the same cycle.
  always_comb begin
    mode_next       = mode_reg;
    plane_next      = plane_reg;
    pending_next    = pending_reg;
    pend_plane_next = pend_plane_reg;
    irqen_next      = irqen_reg;
    flag_next       = flag_reg;
    cnt_next        = cnt_reg;

    if (frame_ev) begin
      flag_next = 1'b1;
      cnt_next  = cnt_reg + FRAME_W'(1);
      if (pending_reg) begin
        plane_next   = pend_plane_reg;
        pending_next = 1'b0;
      end
    end

    if (wr_commit) begin
      case (addr_s)
        REG_MODE: mode_next = mode_e'(din_s[1:0]);
        REG_PLANE: begin
          if (din_s[PLANE_DEFER_BIT]) begin
            pend_plane_next = din_s[PLANE_SEL_BIT];
            pending_next    = 1'b1;
          end else begin
            plane_next   = din_s[PLANE_SEL_BIT];
            pending_next = 1'b0;
          end
        end
        REG_STATUS: begin
          if (din_s[STATUS_CLEAR_BIT] && !frame_ev) flag_next = 1'b0;
        end
        REG_IRQEN: irqen_next = din_s[IRQEN_BIT];
        REG_FRAME: cnt_next = '0;
        default: ;
      endcase
    end
  end

  // Read multiplexer; unused bits and unmapped indices read as zero.
  always_comb begin
    rd_data = '0;
    case (addr_s)
      REG_MODE: rd_data[1:0] = mode_reg;
      REG_PLANE: begin
        rd_data[PLANE_SEL_BIT]   = plane_reg;
        rd_data[PLANE_DEFER_BIT] = pending_reg;
      end
      REG_STATUS: begin
        rd_data[STATUS_VSYNC_BIT] = vs_s;
        rd_data[STATUS_FLAG_BIT]  = flag_reg;
        rd_data[STATUS_PEND_BIT]  = pending_reg;
      end
      REG_IRQEN: rd_data[IRQEN_BIT] = irqen_reg;
      REG_FRAME: rd_data = 8'(cnt_reg);
      default: ;
    endcase
  end

  // State, read data, transceiver enable and interrupt registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_reg       <= MODE_TEXT;
      plane_reg      <= 1'b0;
      pending_reg    <= 1'b0;
      pend_plane_reg <= 1'b0;
      irqen_reg      <= 1'b0;
      flag_reg       <= 1'b0;
      cnt_reg        <= '0;
      dout_reg       <= '0;
      dout_en_reg    <= 1'b0;
      irq_reg        <= 1'b0;
    end else begin
      mode_reg       <= mode_next;
      plane_reg      <= plane_next;
      pending_reg    <= pending_next;
      pend_plane_reg <= pend_plane_next;
      irqen_reg      <= irqen_next;
      flag_reg       <= flag_next;
      cnt_reg        <= cnt_next;
      dout_reg       <= rd_data;
      dout_en_reg    <= ~cs_s & ~rd_s;
      irq_reg        <= flag_reg & irqen_reg;
    end
  end

  assign mode    = mode_reg;
  assign plane   = plane_reg;
  assign dout    = dout_reg;
  assign dout_en = dout_en_reg;
  assign irq     = irq_reg;

endmodule
